// File: rtl/stopwatch_pkg.sv
// +----------------------------------------------------------------------+
// | stopwatch_pkg: shared FSM encodings and 7-segment decode helpers.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = 7'h00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_7seg.sv
// +----------------------------------------------------------------------+
// | bcd_to_7seg: combinational BCD digit to 7-segment pattern decoder.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_to_7seg
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_decode(bcd_i);

endmodule

`default_nettype wire

// File: rtl/stopwatch0_99_ctrl.sv
// +----------------------------------------------------------------------+
// | stopwatch0_99_ctrl: run/pause/clear 00-99 BCD stopwatch, muxed 7seg. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module stopwatch0_99_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50,
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned SEG_INV  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [3:0]    ones_q, ones_d, tens_q, tens_d;
  logic          wrap_q, wrap_d;
  logic          running_q;
  logic          dsel_q, dsel_d;
  logic          advance, tick;
  logic [3:0]    mux_digit;
  logic [6:0]    seg_raw;
  logic [1:0]    dig_raw;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (stop) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (start) begin
      if (state_q == ST_IDLE || state_q == ST_PAUSE) state_d = ST_RUN;
    end
  end

  // A stop or clear on the terminal edge suppresses both advance and increment
  assign advance = (state_q == ST_RUN) && !clear && !stop;
  assign tick    = advance && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    wrap_d  = 1'b0;
    if (clear) begin
      presc_d = '0;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
    end else if (advance) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          if (tens_q == 4'd9) begin
            tens_d = 4'd0;
            wrap_d = 1'b1;
          end else begin
            tens_d = tens_q + 4'd1;
          end
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    scan_d = scan_q + 1'b1;
    dsel_d = dsel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      dsel_d = ~dsel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      scan_q    <= '0;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
      dsel_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      scan_q    <= scan_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      wrap_q    <= wrap_d;
      running_q <= (state_d == ST_RUN);
      dsel_q    <= dsel_d;
    end
  end

  assign mux_digit = dsel_q ? tens_q : ones_q;
  assign dig_raw   = dsel_q ? 2'b10 : 2'b01;

  bcd_to_7seg u_dec (
    .bcd_i (mux_digit),
    .seg_o (seg_raw)
  );

  generate
    if (SEG_INV != 0) begin : g_inv
      assign seg     = ~seg_raw;
      assign dig_sel = ~dig_raw;
    end else begin : g_noinv
      assign seg     = seg_raw;
      assign dig_sel = dig_raw;
    end
  endgenerate

  assign ones    = ones_q;
  assign tens    = tens_q;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch0_99_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_stopwatch0_99_ctrl: directed self-checking bench, TICK_DIV=4.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_stopwatch0_99_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] seg, iseg;
  logic [1:0] dig_sel, idig;
  logic [3:0] ones, tens, iones, itens;
  logic       running, wrap, irunning, iwrap;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  stopwatch0_99_ctrl #(.TICK_DIV(4), .SCAN_DIV(2), .SEG_INV(0)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .seg(seg), .dig_sel(dig_sel), .ones(ones), .tens(tens),
    .running(running), .wrap(wrap)
  );

  stopwatch0_99_ctrl #(.TICK_DIV(4), .SCAN_DIV(2), .SEG_INV(1)) dut_inv (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .seg(iseg), .dig_sel(idig), .ones(iones), .tens(itens),
    .running(irunning), .wrap(iwrap)
  );

  task automatic wait_count(input logic [3:0] t, input logic [3:0] o,
                            input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (tens == t && ones == o) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({tens, ones, running, wrap} !== 10'd0)
      $display("FAIL reset_regs: got t=%0d o=%0d run=%b wrap=%b, expected all 0", tens, ones, running, wrap);
    else pass_cnt++;
    total_cnt++;
    if (dig_sel !== 2'b01 || seg !== 7'h3F)
      $display("FAIL reset_display: got dig=%b seg=%h, expected dig=01 seg=3f", dig_sel, seg);
    else pass_cnt++;
    total_cnt++;
    if (idig !== 2'b10 || iseg !== 7'h40)
      $display("FAIL reset_display_inv: got dig=%b seg=%h, expected dig=10 seg=40", idig, iseg);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (dig_sel !== 2'b01)
      $display("FAIL scan_first_slot: got dig=%b, expected 01", dig_sel);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (dig_sel !== 2'b10 || seg !== 7'h3F || running !== 1'b0)
      $display("FAIL scan_first_toggle: got dig=%b seg=%h run=%b, expected dig=10 seg=3f run=0", dig_sel, seg, running);
    else pass_cnt++;
  endtask

  task automatic test_start_timing;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (running !== 1'b1 || ones !== 4'd0)
      $display("FAIL start_running: got run=%b ones=%0d, expected run=1 ones=0", running, ones);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (ones !== 4'd0)
      $display("FAIL start_n3: got ones=%0d, expected 0", ones);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (ones !== 4'd1)
      $display("FAIL start_n4: got ones=%0d, expected 1", ones);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (ones !== 4'd2 || tens !== 4'd0)
      $display("FAIL start_n8: got t=%0d o=%0d, expected t=0 o=2", tens, ones);
    else pass_cnt++;
  endtask

  task automatic test_priority;
    bit ok;
    wait_count(4'd3, 4'd7, 400, ok);
    total_cnt++;
    if (!ok) $display("FAIL reach_37: got t=%0d o=%0d, expected 37 within budget", tens, ones);
    else pass_cnt++;
    clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    total_cnt++;
    if (running !== 1'b0 || {tens, ones} !== 8'h00)
      $display("FAIL clear_start: got run=%b t=%0d o=%0d, expected run=0 00", running, tens, ones);
    else pass_cnt++;
    repeat (8) @(negedge clk);
    total_cnt++;
    if (running !== 1'b0 || {tens, ones} !== 8'h00)
      $display("FAIL idle_hold: got run=%b t=%0d o=%0d, expected run=0 00", running, tens, ones);
    else pass_cnt++;
    start = 1'b1;
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    total_cnt++;
    if (running !== 1'b0)
      $display("FAIL stop_start: got run=%b, expected 0", running);
    else pass_cnt++;
    repeat (10) @(negedge clk);
    total_cnt++;
    if ({tens, ones} !== 8'h00)
      $display("FAIL pause_hold: got t=%0d o=%0d, expected 00", tens, ones);
    else pass_cnt++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (running !== 1'b1)
      $display("FAIL resume: got run=%b, expected 1", running);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    bit ok;
    wait_count(4'd9, 4'd9, 600, ok);
    total_cnt++;
    if (!ok || wrap !== 1'b0)
      $display("FAIL reach_99: got t=%0d o=%0d wrap=%b, expected 99 wrap=0", tens, ones, wrap);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({tens, ones} !== 8'h99 || wrap !== 1'b0)
      $display("FAIL hold_99: got t=%0d o=%0d wrap=%b, expected 99 wrap=0", tens, ones, wrap);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({tens, ones} !== 8'h00 || wrap !== 1'b1 || running !== 1'b1)
      $display("FAIL rollover: got t=%0d o=%0d wrap=%b run=%b, expected 00 wrap=1 run=1", tens, ones, wrap, running);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (wrap !== 1'b0 || running !== 1'b1)
      $display("FAIL wrap_pulse: got wrap=%b run=%b, expected wrap=0 run=1", wrap, running);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    wait_count(4'd5, 4'd7, 400, ok);
    total_cnt++;
    if (!ok) $display("FAIL reach_57: got t=%0d o=%0d, expected 57 within budget", tens, ones);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({tens, ones, running, wrap} !== 10'd0 || dig_sel !== 2'b01 || seg !== 7'h3F)
      $display("FAIL reset_mid_run: got t=%0d o=%0d run=%b dig=%b seg=%h, expected 00 run=0 dig=01 seg=3f",
               tens, ones, running, dig_sel, seg);
    else pass_cnt++;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    total_cnt++;
    if (running !== 1'b0 || {tens, ones} !== 8'h00)
      $display("FAIL post_reset_idle: got run=%b t=%0d o=%0d, expected run=0 00", running, tens, ones);
    else pass_cnt++;
  endtask

  task automatic test_pause;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total_cnt++;
    if (running !== 1'b0 || ones !== 4'd0)
      $display("FAIL pause_at2: got run=%b ones=%0d, expected run=0 ones=0", running, ones);
    else pass_cnt++;
    repeat (20) @(negedge clk);
    total_cnt++;
    if ({tens, ones} !== 8'h00 || running !== 1'b0)
      $display("FAIL pause_frozen: got t=%0d o=%0d run=%b, expected 00 run=0", tens, ones, running);
    else pass_cnt++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (ones !== 4'd0 || running !== 1'b1)
      $display("FAIL resume_m1: got ones=%0d run=%b, expected ones=0 run=1", ones, running);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (ones !== 4'd1)
      $display("FAIL resume_m2: got ones=%0d, expected 1", ones);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total_cnt++;
    if (ones !== 4'd1 || running !== 1'b0)
      $display("FAIL stop_terminal: got ones=%0d run=%b, expected ones=1 run=0", ones, running);
    else pass_cnt++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (ones !== 4'd1)
      $display("FAIL resume_terminal_m0: got ones=%0d, expected 1", ones);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (ones !== 4'd2)
      $display("FAIL resume_terminal_m1: got ones=%0d, expected 2", ones);
    else pass_cnt++;
  endtask

  task automatic test_scan;
    bit ok;
    logic [1:0] v, exp_d;
    logic [6:0] exp_s;
    wait_count(4'd4, 4'd2, 400, ok);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total_cnt++;
    if (!ok || {tens, ones} !== 8'h42)
      $display("FAIL reach_42: got t=%0d o=%0d, expected 42", tens, ones);
    else pass_cnt++;
    v = dig_sel;
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(negedge clk);
      if (dig_sel != v) ok = 1'b1;
    end
    total_cnt++;
    if (!ok) $display("FAIL scan_toggle: got dig=%b constant, expected a toggle", dig_sel);
    else pass_cnt++;
    v = dig_sel;
    for (int k = 0; k < 8; k++) begin
      exp_d = ((k / 2) % 2 == 0) ? v : ~v;
      exp_s = (exp_d == 2'b01) ? 7'h5B : 7'h66;
      total_cnt++;
      if (dig_sel !== exp_d || seg !== exp_s)
        $display("FAIL scan_k%0d: got dig=%b seg=%h, expected dig=%b seg=%h", k, dig_sel, seg, exp_d, exp_s);
      else pass_cnt++;
      total_cnt++;
      if (idig !== ~exp_d || iseg !== ~exp_s)
        $display("FAIL scan_inv_k%0d: got dig=%b seg=%h, expected dig=%b seg=%h", k, idig, iseg, ~exp_d, ~exp_s);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_start_timing();
    test_priority();
    test_wrap();
    test_reset_mid_run();
    test_pause();
    test_scan();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
